// File: rtl/sdram_command_pkg.sv
// Shared types for the SDRAM controller command interface: command encoding,
// responder FSM states and the fixed bus widths.
package sdram_command_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 22;

    typedef enum logic [1:0] {
        CMD_IDLE     = 2'd0,
        CMD_WRITE    = 2'd1,
        CMD_READ     = 2'd2,
        CMD_RESERVED = 2'd3
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE_ACK,
        ST_WRITE_SAMPLE,
        ST_READ_LATENCY,
        ST_READ_BURST,
        ST_REFRESH
    } responder_state_e;

endpackage

// File: rtl/responder_ram.sv
// Single-port block RAM with synchronous read; no reset so contents survive
// a controller reset.
module responder_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write-on-enable plus a registered read of the same address every cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_command_responder.sv
// Block-RAM stand-in for the SDRAM controller: answers write/read bursts with
// SDRAM-like timing and periodically blocks the bus for a refresh.
//
// state           | meaning
// ----------------+-------------------------------------------------------
// ST_IDLE         | waiting; refresh wins over write, write over read
// ST_WRITE_ACK    | done pulse for the word just written; inputs ignored
// ST_WRITE_SAMPLE | write the next burst word from the current inputs
// ST_READ_LATENCY | CAS wait; RAM read pipeline is primed here
// ST_READ_BURST   | one valid word per cycle from the latched address
// ST_REFRESH      | bus blocked for REFRESH_CYCLES cycles
module sdram_command_responder #(
    parameter int MEM_ADDR_WIDTH    = 10,
    parameter int WRITE_BURST       = 1,
    parameter int READ_BURST_LENGTH = 8,
    parameter int CAS_LATENCY       = 3,
    parameter int REFRESH_PERIOD    = 1024,
    parameter int REFRESH_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  command,
    input  logic [21:0] data_address,
    input  logic [15:0] data_write,
    output logic        data_write_done,
    output logic        data_read_valid,
    output logic [15:0] data_read,
    output logic        refresh_active
);

    import sdram_command_pkg::*;

    localparam int REF_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int RLEN_W = $clog2(REFRESH_CYCLES + 1);

    localparam logic [7:0]                RD_LEN    = 8'(READ_BURST_LENGTH);
    localparam logic [7:0]                WR_LEN    = (WRITE_BURST != 0) ? 8'(READ_BURST_LENGTH) : 8'd1;
    localparam logic [2:0]                LAT_LOAD  = 3'(CAS_LATENCY - 1);
    localparam logic [REF_W-1:0]          REF_LAST  = REF_W'(REFRESH_PERIOD - 1);
    localparam logic [RLEN_W-1:0]         RLEN_LOAD = RLEN_W'(REFRESH_CYCLES - 1);
    // With CL=1 the first RAM read is issued from IDLE, so the pointer starts one ahead.
    localparam logic [MEM_ADDR_WIDTH-1:0] PTR_SKEW  = MEM_ADDR_WIDTH'((CAS_LATENCY == 1) ? 1 : 0);

    responder_state_e            state_q, state_d;
    sdram_cmd_e                  cmd;
    logic [7:0]                  burst_cnt_q, burst_cnt_d;
    logic [2:0]                  lat_cnt_q, lat_cnt_d;
    logic [REF_W-1:0]            ref_cnt_q, ref_cnt_d;
    logic                        ref_due_q, ref_due_d;
    logic [RLEN_W-1:0]           ref_len_q, ref_len_d;
    logic [MEM_ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic                        done_q, valid_q, active_q;
    logic [15:0]                 data_q;

    logic                        ram_we;
    logic [MEM_ADDR_WIDTH-1:0]   ram_addr;
    logic [15:0]                 ram_rdata;
    logic                        enter_refresh;
    logic                        ref_hit;
    logic                        unused_addr_hi;

    assign cmd            = sdram_cmd_e'(command);
    assign unused_addr_hi = ^data_address[21:MEM_ADDR_WIDTH];

    responder_ram #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (data_write),
        .rdata_o (ram_rdata)
    );

    // Next-state logic, burst/latency counters and RAM port control.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        ref_len_d   = ref_len_q;
        rd_ptr_d    = rd_ptr_q;
        ram_we      = 1'b0;
        ram_addr    = data_address[MEM_ADDR_WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (ref_due_q) begin
                    ref_len_d = RLEN_LOAD;
                    state_d   = ST_REFRESH;
                end else if (cmd == CMD_WRITE) begin
                    ram_we      = 1'b1;
                    burst_cnt_d = 8'd1;
                    state_d     = ST_WRITE_ACK;
                end else if (cmd == CMD_READ) begin
                    rd_ptr_d  = data_address[MEM_ADDR_WIDTH-1:0] + PTR_SKEW;
                    lat_cnt_d = LAT_LOAD;
                    state_d   = ST_READ_LATENCY;
                end
            end
            ST_WRITE_ACK: begin
                if (burst_cnt_q == WR_LEN) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE_SAMPLE;
                end
            end
            ST_WRITE_SAMPLE: begin
                ram_we      = 1'b1;
                burst_cnt_d = burst_cnt_q + 8'd1;
                state_d     = ST_WRITE_ACK;
            end
            ST_READ_LATENCY: begin
                ram_addr = rd_ptr_q;
                // Reads start two cycles before the first valid word.
                if (lat_cnt_q <= 3'd1) begin
                    rd_ptr_d = rd_ptr_q + MEM_ADDR_WIDTH'(1);
                end
                if (lat_cnt_q == 3'd0) begin
                    burst_cnt_d = 8'd1;
                    state_d     = ST_READ_BURST;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            ST_READ_BURST: begin
                ram_addr = rd_ptr_q;
                rd_ptr_d = rd_ptr_q + MEM_ADDR_WIDTH'(1);
                if (burst_cnt_q == RD_LEN) begin
                    state_d = ST_IDLE;
                end else begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            ST_REFRESH: begin
                if (ref_len_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ref_len_d = ref_len_q - RLEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The RAM is never written while reset is being sampled.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Free-running refresh timer and the sticky request it raises.
    always_comb begin
        enter_refresh = (state_q == ST_IDLE) && ref_due_q;
        ref_hit       = (ref_cnt_q == REF_LAST);
        ref_cnt_d     = ref_hit ? '0 : ref_cnt_q + REF_W'(1);
        ref_due_d     = ref_hit | (ref_due_q & ~enter_refresh);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            lat_cnt_q   <= '0;
            ref_cnt_q   <= '0;
            ref_due_q   <= 1'b0;
            ref_len_q   <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_due_q   <= ref_due_d;
            ref_len_q   <= ref_len_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= (state_d == ST_WRITE_ACK);
            valid_q     <= (state_d == ST_READ_BURST);
            active_q    <= (state_d == ST_REFRESH);
            data_q      <= (state_d == ST_READ_BURST) ? ram_rdata : '0;
        end
    end

    assign data_write_done = done_q;
    assign data_read_valid = valid_q;
    assign data_read       = data_q;
    assign refresh_active  = active_q;

endmodule

// File: tb/tb_sdram_command_responder.sv
// Directed plus randomized bench for sdram_command_responder. A burst-capable
// instance and a single-word-write instance share clock, reset and bus inputs.
module tb_sdram_command_responder;

    import sdram_command_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int BL    = 8;
    localparam int CL    = 3;
    localparam int RP    = 256;
    localparam int RC    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel_b;
    logic [1:0]  cmd_drv;
    logic [1:0]  command_a, command_b;
    logic [21:0] addr_drv;
    logic [15:0] data_drv;
    logic        done_a, valid_a, ref_a;
    logic        done_b, valid_b, ref_b;
    logic [15:0] rd_a, rd_b;

    int vectors     = 0;
    int miscompares = 0;
    int n_edges     = 0;
    int serviced    = 0;

    logic [15:0] mem_m   [2][DEPTH];
    bit          known_m [2][DEPTH];

    assign command_a = sel_b ? CMD_IDLE : cmd_drv;
    assign command_b = sel_b ? cmd_drv  : CMD_IDLE;

    sdram_command_responder #(
        .MEM_ADDR_WIDTH (AW), .WRITE_BURST (1), .READ_BURST_LENGTH (BL),
        .CAS_LATENCY (CL), .REFRESH_PERIOD (RP), .REFRESH_CYCLES (RC)
    ) u_dut (
        .clk (clk), .reset (reset), .command (command_a),
        .data_address (addr_drv), .data_write (data_drv),
        .data_write_done (done_a), .data_read_valid (valid_a),
        .data_read (rd_a), .refresh_active (ref_a)
    );

    sdram_command_responder #(
        .MEM_ADDR_WIDTH (AW), .WRITE_BURST (0), .READ_BURST_LENGTH (BL),
        .CAS_LATENCY (CL), .REFRESH_PERIOD (RP), .REFRESH_CYCLES (RC)
    ) u_dut_single (
        .clk (clk), .reset (reset), .command (command_b),
        .data_address (addr_drv), .data_write (data_drv),
        .data_write_done (done_b), .data_read_valid (valid_b),
        .data_read (rd_b), .refresh_active (ref_b)
    );

    always #5 clk = ~clk;

    // Clock edges since reset was last sampled; refresh requests land every RP edges.
    always @(posedge clk) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    function automatic bit refresh_due_m();
        return (n_edges / RP) > serviced;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; checks this cycle's outputs at the falling edge.
    task automatic cycle_check(input string tag, input logic e_done, input logic e_valid,
                               input bit check_data, input logic [15:0] e_data, input logic e_ref);
        @(negedge clk);
        chk({tag, "/done"},    {15'd0, sel_b ? done_b  : done_a},  {15'd0, e_done});
        chk({tag, "/valid"},   {15'd0, sel_b ? valid_b : valid_a}, {15'd0, e_valid});
        chk({tag, "/refresh"}, {15'd0, sel_b ? ref_b   : ref_a},   {15'd0, e_ref});
        if (check_data) chk({tag, "/data"}, sel_b ? rd_b : rd_a, e_data);
        @(posedge clk);
        #1;
    endtask

    task automatic service_refresh_if_due();
        for (int g = 0; g < 4 && refresh_due_m(); g++) begin
            serviced = n_edges / RP;
            cycle_check("refresh_entry", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            repeat (RC) cycle_check("refresh", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        end
    endtask

    task automatic idle_cycles(input int n, input logic [1:0] c);
        cmd_drv = c;
        for (int i = 0; i < n; i++) begin
            service_refresh_if_due();
            cycle_check("idle", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic wait_for_due();
        cmd_drv = CMD_IDLE;
        for (int g = 0; g < 2 * RP && !refresh_due_m(); g++)
            cycle_check("pre_refresh", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    // Issues one command as an initiator would; abort_at > 0 asserts reset
    // after that many valid read words.
    task automatic run_cmd(input logic [1:0] c, input logic [21:0] a,
                           input logic [15:0] d, input int abort_at);
        int len;
        int idx;
        int inst;
        inst     = sel_b ? 1 : 0;
        cmd_drv  = c;
        addr_drv = a;
        data_drv = d;
        service_refresh_if_due();
        if (c == CMD_WRITE) begin
            len = sel_b ? 1 : BL;
            for (int k = 0; k < len; k++) begin
                idx = int'(addr_drv[AW-1:0]);
                mem_m[inst][idx]   = data_drv;
                known_m[inst][idx] = 1'b1;
                cycle_check("wr_sample", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
                cycle_check("wr_done",   1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
                addr_drv = addr_drv + 22'd1;
                data_drv = data_drv + 16'd1;
            end
            cmd_drv = CMD_IDLE;
        end else begin
            cycle_check("rd_accept", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            repeat (CL) cycle_check("rd_latency", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            for (int i = 0; i < BL; i++) begin
                idx = (int'(a[AW-1:0]) + i) % DEPTH;
                if (abort_at > 0 && i == abort_at) reset = 1'b1;
                cycle_check("rd_word", 1'b0, 1'b1, known_m[inst][idx], mem_m[inst][idx], 1'b0);
                if (reset) begin
                    reset    = 1'b0;
                    cmd_drv  = CMD_IDLE;
                    serviced = 0;
                    cycle_check("rd_after_reset", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
                    return;
                end
            end
            cmd_drv = CMD_IDLE;
        end
    endtask

    initial begin
        logic [21:0] a;
        logic [21:0] last_wr;
        logic [15:0] d;
        int          r;

        reset    = 1'b1;
        sel_b    = 1'b0;
        cmd_drv  = CMD_IDLE;
        addr_drv = '0;
        data_drv = '0;
        last_wr  = '0;
        repeat (3) @(posedge clk);
        #1;
        cycle_check("reset", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        reset = 1'b0;

        // Quiet bus after reset.
        for (int i = 0; i < 100; i++)
            cycle_check("quiet", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);

        // Write burst then an immediate read-back of the same words.
        run_cmd(CMD_WRITE, 22'h000010, 16'h0010, 0);
        run_cmd(CMD_READ,  22'h000010, 16'h0000, 0);

        // Fill the top and bottom of RAM with address-valued data, read across the wrap.
        run_cmd(CMD_WRITE, 22'h0003F8, 16'h03F8, 0);
        run_cmd(CMD_WRITE, 22'h000000, 16'h0000, 0);
        run_cmd(CMD_READ,  22'h0003FC, 16'h0000, 0);

        // Read presented on the very cycle refresh becomes due.
        wait_for_due();
        run_cmd(CMD_READ, 22'h000010, 16'h0000, 0);

        // Reset partway through a read; RAM keeps its contents.
        run_cmd(CMD_READ, 22'h000010, 16'h0000, 3);
        run_cmd(CMD_READ, 22'h000010, 16'h0000, 0);

        // Randomized traffic, including refresh collisions as they happen to fall.
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            a = 22'($urandom);
            d = 16'($urandom);
            if (r < 4) begin
                run_cmd(CMD_WRITE, a, d, 0);
                last_wr = a;
            end else if (r < 8) begin
                run_cmd(CMD_READ, (r < 6) ? last_wr : a, 16'h0000, 0);
            end else begin
                idle_cycles(int'($urandom_range(1, 5)), (r == 8) ? CMD_IDLE : CMD_RESERVED);
            end
        end

        // Reserved command is ignored.
        idle_cycles(50, CMD_RESERVED);
        cmd_drv = CMD_IDLE;

        // Single-word-write instance.
        sel_b = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle_check("reset_b", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        reset    = 1'b0;
        serviced = 0;
        for (int n = 0; n < 6; n++) begin
            a = 22'($urandom);
            d = 16'($urandom);
            run_cmd(CMD_WRITE, a, d, 0);
            run_cmd(CMD_READ,  a, 16'h0000, 0);
        end
        idle_cycles(50, CMD_RESERVED);
        cmd_drv = CMD_IDLE;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
